// File: rtl/turn_score_ctrl.sv
// Game-flow controller: player count, turn index, position counters, turn timer, winner detection.
// Latency: every output is registered and reflects an input one clock after it is sampled.
// Backpressure: none; start/match/miss/tick are single-cycle pulses and are always accepted or ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin game from IDLE / acknowledge result in WIN
//   n_sel[1:0]            player-count code sampled on start (00=2, 01=3, 10=4, 11 rejected)
//   match, miss, tick     current-player events and turn-timer timebase
//   T, N                  current turn index and latched player-count code
//   p1_cnt..p4_cnt        player positions
//   time_left             ticks remaining in the current turn
//   playing, game_over    state flags (PLAY / WIN)
//   winner                winning player index, meaningful while game_over=1
module turn_score_ctrl #(
   parameter int CNT_W      = 5,
   parameter int GOAL       = 24,
   parameter int TURN_LIMIT = 10,
   parameter int TIME_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        n_sel,
   input  logic              match,
   input  logic              miss,
   input  logic              tick,
   output logic [1:0]        T,
   output logic [1:0]        N,
   output logic [CNT_W-1:0]  p1_cnt,
   output logic [CNT_W-1:0]  p2_cnt,
   output logic [CNT_W-1:0]  p3_cnt,
   output logic [CNT_W-1:0]  p4_cnt,
   output logic [TIME_W-1:0] time_left,
   output logic              playing,
   output logic              game_over,
   output logic [1:0]        winner
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_WIN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]  GOAL_V    = CNT_W'(GOAL);
   localparam logic [CNT_W-1:0]  GOAL_M1_V = CNT_W'(GOAL - 1);
   localparam logic [TIME_W-1:0] LIMIT_V   = TIME_W'(TURN_LIMIT);
   localparam logic [TIME_W-1:0] ONE_V     = TIME_W'(1);

   state_t                  state_q, state_d;
   logic [1:0]              t_q, t_d;
   logic [1:0]              n_q, n_d;
   logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [TIME_W-1:0]       time_q, time_d;
   logic [1:0]              winner_q, winner_d;
   logic                    playing_q, game_over_q;

   // Highest legal turn index is N+1; n_q never holds 11, so this cannot overflow.
   logic [1:0] last_t;
   logic [1:0] next_t;
   assign last_t = n_q + 2'd1;
   assign next_t = (t_q == last_t) ? 2'd0 : t_q + 2'd1;

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      time_d   = time_q;
      winner_d = winner_q;

      unique case (state_q)
         S_IDLE: begin
            if (start && (n_sel != 2'b11)) begin
               n_d      = n_sel;
               cnt_d    = '0;
               t_d      = 2'd0;
               time_d   = LIMIT_V;
               winner_d = 2'd0;
               state_d  = S_PLAY;
            end
         end

         S_PLAY: begin
            // match and miss together cancel each other; that case falls through to tick.
            if (match && !miss) begin
               time_d = LIMIT_V;
               if (cnt_q[t_q] == GOAL_M1_V) begin
                  cnt_d[t_q] = GOAL_V;
                  winner_d   = t_q;
                  state_d    = S_WIN;
               end else begin
                  cnt_d[t_q] = cnt_q[t_q] + 1'b1;
               end
            end else if (miss && !match) begin
               t_d    = next_t;
               time_d = LIMIT_V;
            end else if (tick) begin
               if (time_q == ONE_V) begin
                  t_d    = next_t;
                  time_d = LIMIT_V;
               end else begin
                  time_d = time_q - ONE_V;
               end
            end
         end

         S_WIN: begin
            // Results stay frozen for display until the next game start clears them.
            if (start) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         t_q         <= 2'd0;
         n_q         <= 2'd0;
         cnt_q       <= '0;
         time_q      <= LIMIT_V;
         winner_q    <= 2'd0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         time_q      <= time_d;
         winner_q    <= winner_d;
         playing_q   <= (state_d == S_PLAY);
         game_over_q <= (state_d == S_WIN);
      end
   end

   assign T         = t_q;
   assign N         = n_q;
   assign p1_cnt    = cnt_q[0];
   assign p2_cnt    = cnt_q[1];
   assign p3_cnt    = cnt_q[2];
   assign p4_cnt    = cnt_q[3];
   assign time_left = time_q;
   assign playing   = playing_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule
